// File: rtl/tx_arbiter_if.sv
// Bundle of arbitration, buffer-select and MAC doorbell signals around tx_arbiter.
// master: the arbiter side. slave: packet sources plus the MAC transmit interface.
interface tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned ADDR_W  = 11
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_maxaddr;
  logic [NUM_REQ-1:0]        grant;
  logic [SEL_W-1:0]          sel;
  logic [NUM_REQ-1:0]        done;
  logic                      err;
  logic                      busy;
  logic [ADDR_W-1:0]         tx_pktbuf_maxaddr;
  logic                      tx_doorbell;
  logic                      tx_available;

  modport master (
    input  req, req_maxaddr, tx_available,
    output grant, sel, done, err, busy, tx_pktbuf_maxaddr, tx_doorbell
  );

  modport slave (
    output req, req_maxaddr, tx_available,
    input  grant, sel, done, err, busy, tx_pktbuf_maxaddr, tx_doorbell
  );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin arbiter and sequencer for the shared Ethernet TX path. Grants one packet
// source, rings the MAC doorbell, follows tx_available through the transmission and
// reports done (and err on a start timeout) back to the owner. All outputs registered.
module tx_arbiter #(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned SEL_W         = 2,
  parameter int unsigned ADDR_W        = 11,
  parameter int unsigned START_TIMEOUT = 64
) (
  input logic          clk,
  input logic          rstn,
  tx_arbiter_if.master bus
);
  localparam int unsigned CNT_W = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StRing,
    StWaitStart,
    StWaitEnd,
    StRelease
  } state_e;

  state_e             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   r_last;
  logic               r_err;
  logic               r_busy;
  logic               r_doorbell;
  logic [ADDR_W-1:0]  r_maxaddr;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_found;
  logic               w_hi_found;
  logic [SEL_W-1:0]   w_hi_idx;
  logic [SEL_W-1:0]   w_lo_idx;
  logic [SEL_W-1:0]   w_winner;
  logic [ADDR_W-1:0]  w_winner_maxaddr;

  // Rotating priority: lowest requester above the last owner, else wrap to lowest overall.
  always_comb begin
    w_found          = 1'b0;
    w_hi_found       = 1'b0;
    w_hi_idx         = '0;
    w_lo_idx         = '0;
    w_winner_maxaddr = '0;
    // Descending scan so the lowest qualifying index is the one left standing.
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        w_found  = 1'b1;
        w_lo_idx = SEL_W'(i);
        if (SEL_W'(i) > r_last) begin
          w_hi_found = 1'b1;
          w_hi_idx   = SEL_W'(i);
        end
      end
    end
    w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (SEL_W'(i) == w_winner) begin
        w_winner_maxaddr = bus.req_maxaddr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Transaction sequencer; every output is a register updated here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= StIdle;
      r_grant    <= '0;
      r_done     <= '0;
      r_sel      <= '0;
      r_last     <= SEL_W'(NUM_REQ - 1);
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_doorbell <= 1'b0;
      r_maxaddr  <= '0;
      r_cnt      <= '0;
    end else begin
      r_doorbell <= 1'b0;
      r_done     <= '0;
      r_err      <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_grant   <= NUM_REQ'(1) << w_winner;
            r_sel     <= w_winner;
            r_maxaddr <= w_winner_maxaddr;
            r_busy    <= 1'b1;
            r_state   <= StArm;
          end
        end
        // One cycle for the external buffer mux to settle on the new sel.
        StArm: r_state <= StRing;
        StRing: begin
          if (bus.tx_available) begin
            r_doorbell <= 1'b1;
            r_cnt      <= '0;
            r_state    <= StWaitStart;
          end
        end
        StWaitStart: begin
          if (!bus.tx_available) begin
            r_state <= StWaitEnd;
          end else if (r_cnt == CntLast) begin
            r_done  <= r_grant;
            r_err   <= 1'b1;
            r_state <= StRelease;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StWaitEnd: begin
          if (bus.tx_available) begin
            r_done  <= r_grant;
            r_state <= StRelease;
          end
        end
        StRelease: begin
          r_last  <= r_sel;
          r_grant <= '0;
          r_sel   <= '0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.grant             = r_grant;
  assign bus.sel               = r_sel;
  assign bus.done              = r_done;
  assign bus.err               = r_err;
  assign bus.busy              = r_busy;
  assign bus.tx_pktbuf_maxaddr = r_maxaddr;
  assign bus.tx_doorbell       = r_doorbell;
endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: directed scenarios plus randomized transactions
// against a pointer-based round-robin model and a small behavioural MAC.
module tb_tx_arbiter;
  localparam int unsigned N  = 3;
  localparam int unsigned SW = 2;
  localparam int unsigned AW = 11;
  localparam int unsigned TO = 64;

  logic clk;
  logic rstn;
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   m_last;

  // MAC model controls
  logic mac_avail;
  logic mac_manual = 1'b0;
  logic man_avail = 1'b1;
  bit   mac_stuck = 1'b0;
  int   mac_drop = 2;
  int   mac_busy = 10;

  tx_arbiter_if #(.NUM_REQ(N), .SEL_W(SW), .ADDR_W(AW)) bus ();

  tx_arbiter #(
    .NUM_REQ      (N),
    .SEL_W        (SW),
    .ADDR_W       (AW),
    .START_TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  assign bus.tx_available = mac_manual ? man_avail : mac_avail;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // MAC: after seeing a doorbell, drop available after mac_drop cycles, raise after mac_busy.
  initial begin : mac_model
    int ph;
    int cnt;
    ph = 0;
    cnt = 0;
    mac_avail = 1'b1;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        ph = 0;
        mac_avail = 1'b1;
      end else begin
        case (ph)
          0: if (bus.tx_doorbell && !mac_stuck && !mac_manual) begin
            cnt = mac_drop;
            ph = 1;
          end
          1: if (cnt <= 1) begin
            mac_avail = 1'b0;
            cnt = mac_busy;
            ph = 2;
          end else cnt--;
          default: if (cnt <= 1) begin
            mac_avail = 1'b1;
            ph = 0;
          end else cnt--;
        endcase
      end
    end
  end

  // Reference rule: first requester at or after (last+1) mod N.
  function automatic int exp_winner(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= int'(N); k++) begin
      int c;
      c = (last + k) % int'(N);
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  task automatic apply_reset();
    bus.req = '0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    m_last = int'(N) - 1;
  endtask

  // Step negedges until done appears; records doorbells and grant deviations on the way.
  task automatic wait_done(input int bound, input logic [N-1:0] g, output bit ok,
                           output logic [N-1:0] dv, output logic ev, output int ndb,
                           output int dbc, output int dc, output int gbad);
    ok = 1'b0; dv = '0; ev = 1'b0; ndb = 0; dbc = 0; dc = 0; gbad = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.tx_doorbell) begin
        ndb++;
        dbc = cyc;
      end
      if (bus.grant !== g) gbad++;
      if (|bus.done) begin
        ok = 1'b1;
        dv = bus.done;
        ev = bus.err;
        dc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++;
    if (bus.grant !== 3'b000) $display("FAIL rst_grant: got %b want 000", bus.grant); else n_pass++;
    n_total++;
    if (bus.sel !== 2'd0) $display("FAIL rst_sel: got %0d want 0", bus.sel); else n_pass++;
    n_total++;
    if (bus.done !== 3'b000) $display("FAIL rst_done: got %b want 000", bus.done); else n_pass++;
    n_total++;
    if (bus.err !== 1'b0) $display("FAIL rst_err: got %b want 0", bus.err); else n_pass++;
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++;
    if (bus.tx_doorbell !== 1'b0) $display("FAIL rst_db: got %b want 0", bus.tx_doorbell);
    else n_pass++;
    n_total++;
    if (bus.tx_pktbuf_maxaddr !== 11'd0)
      $display("FAIL rst_maxaddr: got %0d want 0", bus.tx_pktbuf_maxaddr);
    else n_pass++;
  endtask

  task automatic test_idle();
    bus.req = '0;
    repeat (5) @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b0 || bus.grant !== 3'b000)
      $display("FAIL idle_noreq: got busy=%b grant=%b want 0/000", bus.busy, bus.grant);
    else n_pass++;
  endtask

  task automatic test_single();
    bit ok; logic [N-1:0] dv; logic ev; int ndb, dbc, dc, gbad;
    mac_drop = 2; mac_busy = 100; mac_stuck = 0;
    bus.req_maxaddr = '0;
    bus.req_maxaddr[0 +: AW] = 11'd64;
    bus.req_maxaddr[AW +: AW] = 11'd500;
    bus.req = 3'b001;
    @(negedge clk);
    n_total++;
    if (bus.grant !== 3'b001) $display("FAIL single_grant: got %b want 001", bus.grant);
    else n_pass++;
    n_total++;
    if (bus.sel !== 2'd0) $display("FAIL single_sel: got %0d want 0", bus.sel); else n_pass++;
    n_total++;
    if (bus.tx_pktbuf_maxaddr !== 11'd64)
      $display("FAIL single_maxaddr: got %0d want 64", bus.tx_pktbuf_maxaddr);
    else n_pass++;
    n_total++;
    if (bus.busy !== 1'b1) $display("FAIL single_busy: got %b want 1", bus.busy); else n_pass++;
    wait_done(300, 3'b001, ok, dv, ev, ndb, dbc, dc, gbad);
    bus.req = '0;
    m_last = 0;
    n_total++;
    if (!ok || dv !== 3'b001 || ev !== 1'b0)
      $display("FAIL single_done: got ok=%0d done=%b err=%b want 1/001/0", ok, dv, ev);
    else n_pass++;
    n_total++;
    if (ndb != 1 || gbad != 0)
      $display("FAIL single_seq: got doorbells=%0d grant_dev=%0d want 1/0", ndb, gbad);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.done !== 3'b000 || bus.busy !== 1'b0 || bus.grant !== 3'b000)
      $display("FAIL single_release: got done=%b busy=%b grant=%b want 000/0/000",
               bus.done, bus.busy, bus.grant);
    else n_pass++;
    n_total++;
    if (bus.tx_pktbuf_maxaddr !== 11'd64)
      $display("FAIL single_maxaddr_hold: got %0d want 64", bus.tx_pktbuf_maxaddr);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok; logic [N-1:0] dv; logic ev; int ndb, dbc, dc, gbad;
    apply_reset();
    mac_drop = 1; mac_busy = 5; mac_stuck = 0;
    bus.req = 3'b111;
    for (int r = 0; r < int'(N); r++) begin
      @(negedge clk);
      n_total++;
      if (bus.grant !== onehot(r))
        $display("FAIL rr_grant%0d: got %b want %b", r, bus.grant, onehot(r));
      else n_pass++;
      wait_done(100, onehot(r), ok, dv, ev, ndb, dbc, dc, gbad);
      n_total++;
      if (!ok || dv !== onehot(r))
        $display("FAIL rr_done%0d: got ok=%0d done=%b want 1/%b", r, ok, dv, onehot(r));
      else n_pass++;
      bus.req = bus.req & ~onehot(r);
      m_last = r;
      @(negedge clk);
    end
    bus.req = 3'b111;
    @(negedge clk);
    n_total++;
    if (bus.grant !== 3'b001) $display("FAIL rr_wrap: got %b want 001", bus.grant);
    else n_pass++;
    wait_done(100, 3'b001, ok, dv, ev, ndb, dbc, dc, gbad);
    bus.req = '0;
    m_last = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok; logic [N-1:0] dv; logic ev; int ndb, dbc, dc, gbad;
    mac_stuck = 1;
    bus.req = 3'b100;
    @(negedge clk);
    n_total++;
    if (bus.grant !== 3'b100) $display("FAIL to_grant: got %b want 100", bus.grant);
    else n_pass++;
    wait_done(200, 3'b100, ok, dv, ev, ndb, dbc, dc, gbad);
    bus.req = '0;
    m_last = 2;
    n_total++;
    if (!ok || dv !== 3'b100 || ev !== 1'b1)
      $display("FAIL to_done: got ok=%0d done=%b err=%b want 1/100/1", ok, dv, ev);
    else n_pass++;
    n_total++;
    if (ndb != 1 || dc - dbc != int'(TO))
      $display("FAIL to_latency: got db=%0d cycles=%0d want 1/%0d", ndb, dc - dbc, TO);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0)
      $display("FAIL to_idle: got busy=%b err=%b want 0/0", bus.busy, bus.err);
    else n_pass++;
    mac_stuck = 0;
  endtask

  task automatic test_ring_wait();
    bit ok; logic [N-1:0] dv; logic ev; int ndb, dbc, dc, gbad;
    int early_db;
    mac_manual = 1'b1;
    man_avail = 1'b0;
    bus.req = 3'b001;
    @(negedge clk);
    n_total++;
    if (bus.grant !== 3'b001) $display("FAIL ring_grant: got %b want 001", bus.grant);
    else n_pass++;
    early_db = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.tx_doorbell) early_db++;
    end
    n_total++;
    if (early_db != 0 || bus.busy !== 1'b1)
      $display("FAIL ring_hold: got doorbells=%0d busy=%b want 0/1", early_db, bus.busy);
    else n_pass++;
    man_avail = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.tx_doorbell !== 1'b1) $display("FAIL ring_db: got %b want 1", bus.tx_doorbell);
    else n_pass++;
    man_avail = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.tx_doorbell !== 1'b0) $display("FAIL ring_db_pulse: got %b want 0", bus.tx_doorbell);
    else n_pass++;
    repeat (3) @(negedge clk);
    man_avail = 1'b1;
    wait_done(10, 3'b001, ok, dv, ev, ndb, dbc, dc, gbad);
    bus.req = '0;
    m_last = 0;
    n_total++;
    if (!ok || dv !== 3'b001 || ev !== 1'b0)
      $display("FAIL ring_done: got ok=%0d done=%b err=%b want 1/001/0", ok, dv, ev);
    else n_pass++;
    @(negedge clk);
    mac_manual = 1'b0;
  endtask

  task automatic test_req_drop();
    bit ok; logic [N-1:0] dv; logic ev; int ndb, dbc, dc, gbad;
    bit seen;
    mac_drop = 2; mac_busy = 20;
    bus.req = 3'b010;
    @(negedge clk);
    n_total++;
    if (bus.grant !== 3'b010) $display("FAIL drop_grant: got %b want 010", bus.grant);
    else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.tx_available === 1'b0) seen = 1'b1;
    end
    n_total++;
    if (!seen) $display("FAIL drop_mac_start: got available=1 want 0 within 30 cycles");
    else n_pass++;
    @(negedge clk);
    bus.req = 3'b100;
    wait_done(100, 3'b010, ok, dv, ev, ndb, dbc, dc, gbad);
    m_last = 1;
    n_total++;
    if (!ok || dv !== 3'b010 || gbad != 0)
      $display("FAIL drop_done: got ok=%0d done=%b grant_dev=%0d want 1/010/0", ok, dv, gbad);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.grant !== 3'b000) $display("FAIL drop_idle: got %b want 000", bus.grant);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.grant !== 3'b100) $display("FAIL drop_next: got %b want 100", bus.grant);
    else n_pass++;
    wait_done(100, 3'b100, ok, dv, ev, ndb, dbc, dc, gbad);
    bus.req = '0;
    m_last = 2;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok; logic [N-1:0] dv; logic ev; int ndb, dbc, dc, gbad;
    bit seen;
    int stray;
    mac_drop = 1; mac_busy = 50;
    bus.req = 3'b001;
    @(negedge clk);
    n_total++;
    if (bus.grant !== 3'b001) $display("FAIL rmid_grant: got %b want 001", bus.grant);
    else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.tx_available === 1'b0) seen = 1'b1;
    end
    @(negedge clk);
    n_total++;
    if (!seen) $display("FAIL rmid_mac_start: got available=1 want 0 within 30 cycles");
    else n_pass++;
    #2 rstn = 1'b0;
    #1;
    n_total++;
    if (bus.grant !== 3'b000 || bus.busy !== 1'b0 || bus.sel !== 2'd0 || bus.done !== 3'b000)
      $display("FAIL rmid_async: got grant=%b busy=%b sel=%0d done=%b want zeros",
               bus.grant, bus.busy, bus.sel, bus.done);
    else n_pass++;
    n_total++;
    if (bus.tx_pktbuf_maxaddr !== 11'd0)
      $display("FAIL rmid_maxaddr: got %0d want 0", bus.tx_pktbuf_maxaddr);
    else n_pass++;
    bus.req = '0;
    @(negedge clk);
    rstn = 1'b1;
    m_last = int'(N) - 1;
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (|bus.done) stray++;
    end
    n_total++;
    if (stray != 0) $display("FAIL rmid_nodone: got %0d done pulses want 0", stray);
    else n_pass++;
    bus.req = 3'b010;
    @(negedge clk);
    n_total++;
    if (bus.grant !== 3'b010 || bus.sel !== 2'd1)
      $display("FAIL rmid_regrant: got grant=%b sel=%0d want 010/1", bus.grant, bus.sel);
    else n_pass++;
    wait_done(200, 3'b010, ok, dv, ev, ndb, dbc, dc, gbad);
    bus.req = '0;
    m_last = 1;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit ok; logic [N-1:0] dv; logic ev; int ndb, dbc, dc, gbad;
    logic [AW-1:0] ma [N];
    logic [N-1:0] r;
    logic [N-1:0] eg;
    int w;
    for (int it = 0; it < 30; it++) begin
      mac_stuck = ($urandom_range(0, 6) == 0);
      mac_drop = $urandom_range(1, 4);
      mac_busy = $urandom_range(1, 30);
      r = N'($urandom_range(1, 7));
      for (int s = 0; s < int'(N); s++) begin
        ma[s] = AW'($urandom);
        bus.req_maxaddr[s*AW +: AW] = ma[s];
      end
      bus.req = r;
      w = exp_winner(r, m_last);
      eg = onehot(w);
      @(negedge clk);
      n_total++;
      if (bus.grant !== eg || bus.sel !== SW'(w))
        $display("FAIL rand_grant it%0d: got %b/%0d want %b/%0d", it, bus.grant, bus.sel, eg, w);
      else n_pass++;
      n_total++;
      if (bus.tx_pktbuf_maxaddr !== ma[w])
        $display("FAIL rand_maxaddr it%0d: got %0d want %0d", it, bus.tx_pktbuf_maxaddr, ma[w]);
      else n_pass++;
      // Inputs that change mid-transaction must not disturb it.
      bus.req = N'($urandom);
      bus.req_maxaddr = (N*AW)'({$urandom, $urandom});
      wait_done(int'(TO) + 80, eg, ok, dv, ev, ndb, dbc, dc, gbad);
      n_total++;
      if (!ok || dv !== eg || ev !== logic'(mac_stuck))
        $display("FAIL rand_done it%0d: got ok=%0d done=%b err=%b want 1/%b/%0d",
                 it, ok, dv, ev, eg, mac_stuck);
      else n_pass++;
      n_total++;
      if (ndb != 1 || gbad != 0 || bus.tx_pktbuf_maxaddr !== ma[w])
        $display("FAIL rand_seq it%0d: got db=%0d grant_dev=%0d addr=%0d want 1/0/%0d",
                 it, ndb, gbad, bus.tx_pktbuf_maxaddr, ma[w]);
      else n_pass++;
      if (mac_stuck) begin
        n_total++;
        if (dc - dbc != int'(TO))
          $display("FAIL rand_timeout it%0d: got %0d want %0d", it, dc - dbc, TO);
        else n_pass++;
      end
      m_last = w;
      bus.req = '0;
      @(negedge clk);
      n_total++;
      if (bus.busy !== 1'b0 || bus.done !== 3'b000)
        $display("FAIL rand_idle it%0d: got busy=%b done=%b want 0/000", it, bus.busy, bus.done);
      else n_pass++;
    end
    mac_stuck = 0;
  endtask

  initial begin
    rstn = 1'b1;
    bus.req = '0;
    bus.req_maxaddr = '0;
    m_last = int'(N) - 1;
    #1 rstn = 1'b0;
    test_reset();
    test_idle();
    test_single();
    test_round_robin();
    test_timeout();
    test_ring_wait();
    test_req_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
